// File: rtl/uartrx.sv
// 8N1 UART receiver: 2-flop synchronised input, mid-bit sampling,
// one-cycle data/error pulses and break detection on a held-low line.
module uartrx #(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] uart_data,
    output logic       uart_ready,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST      = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic [7:0]    data_n;
    logic          rdy_n, ferr_n;
    logic          rx_meta, rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            uart_data  <= '0;
            uart_ready <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            sh         <= sh_n;
            uart_data  <= data_n;
            uart_ready <= rdy_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        data_n  = uart_data;
        rdy_n   = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n     = '0;
                    sh_n[idx] = rx_s;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = sh;
                        rdy_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uartrx.sv
// Scoreboard bench for uartrx at CLK_DIV=16: stimulus pushes expected
// pulses, a monitor pops and compares whenever the receiver pulses.
module tb_uartrx;

    localparam int DIV = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] uart_data;
    logic       uart_ready;
    logic       frame_err;
    logic       busy;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   rdy_t[$];
    int   cyc;
    int   checks;
    int   errors;

    uartrx #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .uart_data  (uart_data),
        .uart_ready (uart_ready),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (uart_ready && frame_err) begin
                chk("ready_and_ferr_together", 1, 0);
            end
            if (uart_ready) begin
                rdy_t.push_back(cyc);
            end
            if (uart_ready || frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {uart_ready, frame_err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_is_ferr", int'(frame_err), int'(e.err));
                    chk("pulse_is_ready", int'(uart_ready), int'(!e.err));
                    chk("uart_data", int'(uart_data), int'(e.data));
                end
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_hold(input logic v);
        rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bit_hold(1'b0);
        for (int i = 0; i < 8; i++) bit_hold(b[i]);
        bit_hold(stop);
    endtask

    task automatic expect_byte(input logic [7:0] d);
        exp_t e;
        e.err  = 1'b0;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_ferr(input logic [7:0] held);
        exp_t e;
        e.err  = 1'b1;
        e.data = held;
        exp_q.push_back(e);
    endtask

    initial begin
        int seen;
        checks = 0;
        errors = 0;
        rx     = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", int'(uart_data), 0);
        chk("reset_ready", int'(uart_ready), 0);
        chk("reset_ferr", int'(frame_err), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b0;

        // Idle line after reset keeps the receiver idle.
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        chk("idle_no_busy", seen, 0);

        // Single frame.
        expect_byte(8'h52);
        send_frame(8'h52, 1'b1);
        chk("busy_after_frame", int'(busy), 0);
        chk("q_after_52", exp_q.size(), 0);
        idle(20);

        // Short low glitch is rejected.
        rx   = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        rx = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        chk("glitch_busy_rose", seen, 1);
        chk("glitch_busy_fell", int'(busy), 0);
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(20);

        // Bad stop bit then a held-low line: one frame error only.
        expect_byte(8'h52);
        send_frame(8'h52, 1'b1);
        expect_ferr(8'h52);
        send_frame(8'h33, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        chk("busy_in_break", int'(busy), 1);
        idle(30);
        chk("busy_after_break", int'(busy), 0);
        chk("data_held_52", int'(uart_data), 8'h52);
        chk("q_after_ferr", exp_q.size(), 0);

        // Back-to-back frames, one-bit stop.
        rdy_t.delete();
        expect_byte(8'h55);
        expect_byte(8'hAA);
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        idle(20);
        chk("b2b_pulses", rdy_t.size(), 2);
        if (rdy_t.size() == 2) begin
            chk("b2b_spacing", rdy_t[1] - rdy_t[0], 160);
        end

        // Reset during bit 3 aborts the frame and clears the data.
        bit_hold(1'b0);
        bit_hold(1'b1);
        bit_hold(1'b0);
        bit_hold(1'b1);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(40);
        chk("abort_busy", int'(busy), 0);
        chk("abort_data_cleared", int'(uart_data), 0);
        expect_byte(8'h41);
        send_frame(8'h41, 1'b1);
        idle(10);

        // Ten consecutive frames.
        rdy_t.delete();
        for (int i = 0; i < 10; i++) begin
            expect_byte(8'h52);
            send_frame(8'h52, 1'b1);
        end
        idle(20);
        chk("ten_pulses", rdy_t.size(), 10);

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
